// File: rtl/alu_pkg.sv
// Shared ALU definitions: datapath sizing, control codes and operand-class helper.
// Imported by the issue stage and by benches that model the ALU.
package alu_pkg;

    localparam int DW   = 8;
    localparam int NREG = 8;
    localparam int AW   = $clog2(NREG);

    localparam logic [3:0] ALU_ADD = 4'b0000;
    localparam logic [3:0] ALU_SUB = 4'b0001;
    localparam logic [3:0] ALU_AND = 4'b1000;
    localparam logic [3:0] ALU_OR  = 4'b1001;
    localparam logic [3:0] ALU_XOR = 4'b1010;
    localparam logic [3:0] ALU_NOT = 4'b1011;
    localparam logic [3:0] ALU_SHL = 4'b1100;
    localparam logic [3:0] ALU_SHR = 4'b1101;
    localparam logic [3:0] ALU_ROR = 4'b1110;
    localparam logic [3:0] ALU_RCL = 4'b1111;

    // Codes 1011..1111 only consume operand A, so rb must not create a hazard.
    function automatic logic is_unary(input logic [3:0] op);
        return (op >= ALU_NOT);
    endfunction

endpackage

// File: rtl/seq_regfile.sv
// General register file for the ALU issue stage: one write port, three
// combinational read ports, all entries cleared by the asynchronous reset.
module seq_regfile
    import alu_pkg::*;
(
    input  logic          ck,
    input  logic          rst_n,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic [AW-1:0] raddr_a,
    output logic [DW-1:0] rdata_a,
    input  logic [AW-1:0] raddr_b,
    output logic [DW-1:0] rdata_b,
    input  logic [AW-1:0] raddr_c,
    output logic [DW-1:0] rdata_c
);

    logic [DW-1:0] regs [NREG];

    always_ff @(posedge ck or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++) begin
                regs[i] <= '0;
            end
        end else if (we) begin
            regs[waddr] <= wdata;
        end
    end

    assign rdata_a = regs[raddr_a];
    assign rdata_b = regs[raddr_b];
    assign rdata_c = regs[raddr_c];

endmodule

// File: rtl/alu_sequencer.sv
// Issue stage for the two-stage 8-bit ALU: handshake, RAW hazard stall,
// operand registers and the three-deep valid/rd chain that drives writeback.
module alu_sequencer
    import alu_pkg::*;
(
    input  logic          ck,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [3:0]    in_op,
    input  logic [AW-1:0] in_ra,
    input  logic [AW-1:0] in_rb,
    input  logic [AW-1:0] in_rd,
    input  logic          ld_valid,
    output logic          ld_ready,
    input  logic [AW-1:0] ld_addr,
    input  logic [DW-1:0] ld_data,
    output logic [DW-1:0] alu_a,
    output logic [DW-1:0] alu_b,
    output logic [3:0]    alu_ctr,
    input  logic [DW-1:0] alu_o,
    output logic          wb_valid,
    output logic [AW-1:0] wb_rd,
    output logic [DW-1:0] wb_data,
    output logic          idle,
    input  logic [AW-1:0] dbg_addr,
    output logic [DW-1:0] dbg_data
);

    // Bit 0 = s1 (issued), bit 1 = s2 (ALU input latch), bit 2 = s3 (O valid).
    logic [2:0]    stg_valid;
    logic [AW-1:0] stg_rd [3];

    logic          hazard;
    logic          accept;
    logic          rf_we;
    logic [AW-1:0] rf_waddr;
    logic [DW-1:0] rf_wdata;
    logic [DW-1:0] rd_a;
    logic [DW-1:0] rd_b;

    always_comb begin
        hazard = 1'b0;
        for (int i = 0; i < 3; i++) begin
            if (stg_valid[i] && ((stg_rd[i] == in_ra) ||
                                 (!is_unary(in_op) && (stg_rd[i] == in_rb)))) begin
                hazard = 1'b1;
            end
        end
    end

    assign in_ready = !ld_valid && !hazard;
    assign accept   = in_valid && in_ready;
    assign idle     = ~|stg_valid;
    assign ld_ready = idle;

    assign wb_valid = stg_valid[2];
    assign wb_rd    = stg_rd[2];
    assign wb_data  = alu_o;

    // Writeback and preload never overlap: preload is only accepted when idle.
    assign rf_we    = wb_valid || (ld_valid && idle);
    assign rf_waddr = wb_valid ? wb_rd : ld_addr;
    assign rf_wdata = wb_valid ? alu_o : ld_data;

    seq_regfile u_regfile (
        .ck      (ck),
        .rst_n   (rst_n),
        .we      (rf_we),
        .waddr   (rf_waddr),
        .wdata   (rf_wdata),
        .raddr_a (in_ra),
        .rdata_a (rd_a),
        .raddr_b (in_rb),
        .rdata_b (rd_b),
        .raddr_c (dbg_addr),
        .rdata_c (dbg_data)
    );

    always_ff @(posedge ck or negedge rst_n) begin
        if (!rst_n) begin
            alu_a   <= '0;
            alu_b   <= '0;
            alu_ctr <= '0;
        end else if (accept) begin
            alu_a   <= rd_a;
            alu_b   <= rd_b;
            alu_ctr <= in_op;
        end
    end

    always_ff @(posedge ck or negedge rst_n) begin
        if (!rst_n) begin
            stg_valid <= '0;
            for (int i = 0; i < 3; i++) begin
                stg_rd[i] <= '0;
            end
        end else begin
            stg_valid <= {stg_valid[1:0], accept};
            stg_rd[0] <= in_rd;
            stg_rd[1] <= stg_rd[0];
            stg_rd[2] <= stg_rd[1];
        end
    end

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed bench for alu_sequencer with a behavioural two-stage ALU attached.
// Inputs change on the falling edge; outputs are sampled 1 time unit later.
module tb_alu_sequencer;
    import alu_pkg::*;

    logic          ck = 1'b0;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [3:0]    in_op;
    logic [AW-1:0] in_ra, in_rb, in_rd;
    logic          ld_valid;
    logic          ld_ready;
    logic [AW-1:0] ld_addr;
    logic [DW-1:0] ld_data;
    logic [DW-1:0] alu_a, alu_b;
    logic [3:0]    alu_ctr;
    logic [DW-1:0] alu_o;
    logic          wb_valid;
    logic [AW-1:0] wb_rd;
    logic [DW-1:0] wb_data;
    logic          idle;
    logic [AW-1:0] dbg_addr;
    logic [DW-1:0] dbg_data;

    int total = 0;
    int bad   = 0;

    always #5 ck = ~ck;

    alu_sequencer dut (
        .ck       (ck),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_op    (in_op),
        .in_ra    (in_ra),
        .in_rb    (in_rb),
        .in_rd    (in_rd),
        .ld_valid (ld_valid),
        .ld_ready (ld_ready),
        .ld_addr  (ld_addr),
        .ld_data  (ld_data),
        .alu_a    (alu_a),
        .alu_b    (alu_b),
        .alu_ctr  (alu_ctr),
        .alu_o    (alu_o),
        .wb_valid (wb_valid),
        .wb_rd    (wb_rd),
        .wb_data  (wb_data),
        .idle     (idle),
        .dbg_addr (dbg_addr),
        .dbg_data (dbg_data)
    );

    // Behavioural ALU: inputs latched on one edge, O produced on the next; no reset.
    function automatic logic [7:0] alu_f(input logic [7:0] a, input logic [7:0] b,
                                         input logic [3:0] c);
        case (c)
            ALU_ADD: return a + b;
            ALU_SUB: return a - b;
            ALU_AND: return a & b;
            ALU_OR:  return a | b;
            ALU_XOR: return a ^ b;
            ALU_NOT: return ~a;
            ALU_SHL: return {a[6:0], 1'b0};
            ALU_SHR: return {1'b0, a[7:1]};
            ALU_ROR: return {a[0], a[7:1]};
            ALU_RCL: return {a[6:0], a[7]};
            default: return 8'h00;
        endcase
    endfunction

    logic [7:0] a_q, b_q;
    logic [3:0] c_q;
    always_ff @(posedge ck) begin
        a_q   <= alu_a;
        b_q   <= alu_b;
        c_q   <= alu_ctr;
        alu_o <= alu_f(a_q, b_q, c_q);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
        $display("check %-16s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic reg_chk(input string tag, input logic [2:0] r, input logic [31:0] exp);
        dbg_addr = r;
        #1;
        check(tag, 32'(dbg_data), exp);
    endtask

    task automatic preload(input logic [2:0] a, input logic [7:0] d);
        int n;
        @(negedge ck);
        ld_valid = 1'b1;
        ld_addr  = a;
        ld_data  = d;
        #1;
        n = 0;
        while (!ld_ready && n < 50) begin
            @(negedge ck);
            #1;
            n++;
        end
        if (n >= 50) check("preload_timeout", 32'(ld_ready), 1);
        @(negedge ck);
        ld_valid = 1'b0;
    endtask

    // Returns on the falling edge right after the accepting edge, with in_valid low.
    task automatic issue(input logic [3:0] op, input logic [2:0] ra, input logic [2:0] rb,
                         input logic [2:0] rd, output int stalls);
        @(negedge ck);
        in_valid = 1'b1;
        in_op    = op;
        in_ra    = ra;
        in_rb    = rb;
        in_rd    = rd;
        #1;
        stalls = 0;
        while (!in_ready && stalls < 50) begin
            @(negedge ck);
            #1;
            stalls++;
        end
        if (stalls >= 50) check("issue_timeout", 32'(in_ready), 1);
        @(negedge ck);
        in_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        #1;
        n = 0;
        while (!idle && n < 50) begin
            @(negedge ck);
            #1;
            n++;
        end
        if (n >= 50) check("idle_timeout", 32'(idle), 1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int st;
        int cnt;
        logic       wbv [9];
        logic [2:0] wbr [9];
        logic [7:0] wbd [9];

        rst_n = 1'b0; in_valid = 1'b0; in_op = '0; in_ra = '0; in_rb = '0; in_rd = '0;
        ld_valid = 1'b0; ld_addr = '0; ld_data = '0; dbg_addr = '0;
        repeat (2) @(negedge ck);
        #1;
        check("rst_idle", 32'(idle), 1);
        check("rst_alu_a", 32'(alu_a), 0);
        check("rst_alu_b", 32'(alu_b), 0);
        check("rst_alu_ctr", 32'(alu_ctr), 0);
        check("rst_wb_valid", 32'(wb_valid), 0);
        check("rst_in_ready", 32'(in_ready), 1);
        reg_chk("rst_R0", 3'd0, 0);
        @(negedge ck);
        rst_n = 1'b1;

        // ADD r3 = r1 + r2, writeback 3 cycles after accept
        preload(3'd1, 8'h05);
        preload(3'd2, 8'h03);
        issue(ALU_ADD, 3'd1, 3'd2, 3'd3, st);
        #1;
        check("add_stalls", 32'(st), 0);
        check("add_alu_a", 32'(alu_a), 'h05);
        check("add_alu_b", 32'(alu_b), 'h03);
        check("add_wb_c1", 32'(wb_valid), 0);
        @(negedge ck); #1;
        check("add_wb_c2", 32'(wb_valid), 0);
        @(negedge ck); #1;
        check("add_wb_c3", 32'(wb_valid), 1);
        check("add_wb_rd", 32'(wb_rd), 3);
        check("add_wb_data", 32'(wb_data), 'h08);
        @(negedge ck);
        wait_idle();
        reg_chk("add_R3", 3'd3, 'h08);

        // SUB r4 = r2 - r1 wraps
        issue(ALU_SUB, 3'd2, 3'd1, 3'd4, st);
        wait_idle();
        reg_chk("sub_R4", 3'd4, 'hFE);

        // RAW: ADD r3 then OR r5 = r3 | r1 back-to-back
        preload(3'd3, 8'h00);
        @(negedge ck);
        in_valid = 1'b1; in_op = ALU_ADD; in_ra = 3'd1; in_rb = 3'd2; in_rd = 3'd3;
        #1;
        check("raw_first_rdy", 32'(in_ready), 1);
        @(negedge ck);
        in_op = ALU_OR; in_ra = 3'd3; in_rb = 3'd1; in_rd = 3'd5;
        #1;
        cnt = 0;
        while (!in_ready && cnt < 20) begin
            @(negedge ck); #1;
            cnt++;
        end
        check("raw_stall_cyc", 32'(cnt), 3);
        @(negedge ck);
        in_valid = 1'b0;
        wait_idle();
        reg_chk("raw_R5", 3'd5, 'h0D);
        reg_chk("raw_R3", 3'd3, 'h08);

        // Four independent ops, one per cycle: AND r4, XOR r6, SUB r7, ADD r0
        for (int k = 0; k < 9; k++) begin
            @(negedge ck);
            case (k)
                0: begin in_valid = 1'b1; in_op = ALU_AND; in_ra = 3'd1; in_rb = 3'd2; in_rd = 3'd4; end
                1: begin in_valid = 1'b1; in_op = ALU_XOR; in_ra = 3'd1; in_rb = 3'd2; in_rd = 3'd6; end
                2: begin in_valid = 1'b1; in_op = ALU_SUB; in_ra = 3'd1; in_rb = 3'd2; in_rd = 3'd7; end
                3: begin in_valid = 1'b1; in_op = ALU_ADD; in_ra = 3'd1; in_rb = 3'd1; in_rd = 3'd0; end
                default: in_valid = 1'b0;
            endcase
            #1;
            if (k < 4) check("burst_ready", 32'(in_ready), 1);
            wbv[k] = wb_valid;
            wbr[k] = wb_rd;
            wbd[k] = wb_data;
        end
        check("burst_wb_pre", 32'(wbv[2]), 0);
        check("burst_wb0_v", 32'(wbv[3]), 1);
        check("burst_wb0_rd", 32'(wbr[3]), 4);
        check("burst_wb0_d", 32'(wbd[3]), 'h01);
        check("burst_wb1_v", 32'(wbv[4]), 1);
        check("burst_wb1_rd", 32'(wbr[4]), 6);
        check("burst_wb1_d", 32'(wbd[4]), 'h06);
        check("burst_wb2_v", 32'(wbv[5]), 1);
        check("burst_wb2_rd", 32'(wbr[5]), 7);
        check("burst_wb2_d", 32'(wbd[5]), 'h02);
        check("burst_wb3_v", 32'(wbv[6]), 1);
        check("burst_wb3_rd", 32'(wbr[6]), 0);
        check("burst_wb3_d", 32'(wbd[6]), 'h0A);
        check("burst_wb_post", 32'(wbv[7]), 0);
        wait_idle();
        reg_chk("burst_R0", 3'd0, 'h0A);
        reg_chk("burst_R7", 3'd7, 'h02);

        // Unary NOT ignores rb in flight; WAW on r6, later op wins
        @(negedge ck);
        in_valid = 1'b1; in_op = ALU_ADD; in_ra = 3'd1; in_rb = 3'd2; in_rd = 3'd6;
        @(negedge ck);
        in_op = ALU_NOT; in_ra = 3'd1; in_rb = 3'd6; in_rd = 3'd6;
        #1;
        check("not_no_stall", 32'(in_ready), 1);
        @(negedge ck);
        in_valid = 1'b0;
        wait_idle();
        reg_chk("not_R6", 3'd6, 'hFA);

        // Undefined code writes back 0
        issue(4'b0101, 3'd1, 3'd2, 3'd4, st);
        wait_idle();
        reg_chk("undef_R4", 3'd4, 'h00);

        // Reset one cycle after accepting ADD into r7
        issue(ALU_ADD, 3'd1, 3'd2, 3'd7, st);
        rst_n = 1'b0;
        #1;
        check("mrst_idle", 32'(idle), 1);
        @(negedge ck);
        rst_n = 1'b1;
        cnt = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge ck); #1;
            if (wb_valid) cnt++;
        end
        check("mrst_wb_pulses", 32'(cnt), 0);
        check("mrst_idle_after", 32'(idle), 1);
        reg_chk("mrst_R7", 3'd7, 'h00);
        reg_chk("mrst_R1", 3'd1, 'h00);

        // Preload requested while an op is in flight waits for idle
        preload(3'd1, 8'h05);
        preload(3'd2, 8'h03);
        issue(ALU_ADD, 3'd1, 3'd2, 3'd3, st);
        ld_valid = 1'b1; ld_addr = 3'd5; ld_data = 8'h77;
        #1;
        cnt = 0;
        while (!ld_ready && cnt < 20) begin
            check("ld_blk_in_rdy", 32'(in_ready), 0);
            @(negedge ck); #1;
            cnt++;
        end
        check("ld_wait_cyc", 32'(cnt), 3);
        check("ld_in_ready", 32'(in_ready), 0);
        @(negedge ck);
        ld_valid = 1'b0;
        reg_chk("ld_R5", 3'd5, 'h77);
        reg_chk("ld_R3", 3'd3, 'h08);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
